// File: rtl/boreal_weight_bus_arbiter.sv
// boreal_weight_bus_arbiter: shares the weight RAM port between host and learner with bounded starvation and a learning freeze gate
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   host_req/we/addr/wdata -> gnt    host request, combinational grant
//   host_rvalid/rdata                host read return (one-cycle pulse)
//   lrn_*                            learner port, same meaning as host_*
//   freeze_set/freeze_clr -> frozen  learning gate (set wins on collision)
//   mem_we/addr/din, mem_dout        registered RAM port, read data RD_LAT cycles after address
//   busy                             any read tag still in flight
module boreal_weight_bus_arbiter #(
   parameter int ADDR_W          = 10,
   parameter int DATA_W          = 32,
   parameter int RD_LAT          = 1,
   parameter int STARVE_MAX      = 16,
   parameter bit FREEZE_ON_RESET = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   input  logic              lrn_req,
   input  logic              lrn_we,
   input  logic [ADDR_W-1:0] lrn_addr,
   input  logic [DATA_W-1:0] lrn_wdata,
   output logic              lrn_gnt,
   output logic              lrn_rvalid,
   output logic [DATA_W-1:0] lrn_rdata,
   input  logic              freeze_set,
   input  logic              freeze_clr,
   output logic              frozen,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy
);
   localparam logic [7:0] SMAX = 8'(STARVE_MAX);
   logic [7:0]      starve_cnt;
   logic            lrn_eligible;
   logic            rd_gnt;
   logic [RD_LAT:0] tag_v;
   logic [RD_LAT:0] tag_s;
   assign lrn_eligible = lrn_req & ~frozen;
   // learner wins when starved out, or whenever the host is idle; grants are held off during reset
   assign lrn_gnt  = rst_n & lrn_eligible & ((starve_cnt == SMAX) | ~host_req);
   assign host_gnt = rst_n & host_req & ~lrn_gnt;
   assign rd_gnt   = host_gnt ? ~host_we : lrn_gnt & ~lrn_we;
   assign busy     = |tag_v;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt  <= '0;
         frozen      <= FREEZE_ON_RESET;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_din     <= '0;
         tag_v       <= '0;
         tag_s       <= '0;
         host_rvalid <= 1'b0;
         lrn_rvalid  <= 1'b0;
         host_rdata  <= '0;
         lrn_rdata   <= '0;
      end else begin
         frozen     <= freeze_set | (frozen & ~freeze_clr);
         starve_cnt <= (lrn_gnt | ~lrn_eligible) ? '0
                     : (host_gnt && starve_cnt != SMAX) ? starve_cnt + 8'd1 : starve_cnt;
         mem_we     <= host_gnt ? host_we : lrn_gnt & lrn_we;
         if (host_gnt | lrn_gnt) begin
            mem_addr <= host_gnt ? host_addr : lrn_addr;
            mem_din  <= host_gnt ? host_wdata : lrn_wdata;
         end
         // tag stage RD_LAT lines up with the cycle mem_dout holds that read's data
         tag_v       <= {tag_v[RD_LAT-1:0], rd_gnt};
         tag_s       <= {tag_s[RD_LAT-1:0], lrn_gnt};
         host_rvalid <= tag_v[RD_LAT] & ~tag_s[RD_LAT];
         lrn_rvalid  <= tag_v[RD_LAT] & tag_s[RD_LAT];
         if (tag_v[RD_LAT] & ~tag_s[RD_LAT]) host_rdata <= mem_dout;
         if (tag_v[RD_LAT] & tag_s[RD_LAT]) lrn_rdata <= mem_dout;
      end
   end
endmodule

// File: tb/tb_boreal_weight_bus_arbiter.sv
// tb_boreal_weight_bus_arbiter: randomized and directed scoreboard bench for the weight bus arbiter
module tb_boreal_weight_bus_arbiter;
   localparam int AW = 10, DW = 32, RL = 1, SM = 16;
   localparam bit FR = 1'b0;
   logic clk = 1'b0, rst_n = 1'b0;
   logic host_req = 0, host_we = 0, lrn_req = 0, lrn_we = 0, freeze_set = 0, freeze_clr = 0;
   logic [AW-1:0] host_addr = '0, lrn_addr = '0, mem_addr;
   logic [DW-1:0] host_wdata = '0, lrn_wdata = '0, host_rdata, lrn_rdata, mem_din, mem_dout;
   logic host_gnt, host_rvalid, lrn_gnt, lrn_rvalid, frozen, mem_we, busy;
   always #5 clk = ~clk;
   boreal_weight_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .STARVE_MAX(SM), .FREEZE_ON_RESET(FR)) dut (
      .clk(clk), .rst_n(rst_n),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .lrn_req(lrn_req), .lrn_we(lrn_we), .lrn_addr(lrn_addr), .lrn_wdata(lrn_wdata),
      .lrn_gnt(lrn_gnt), .lrn_rvalid(lrn_rvalid), .lrn_rdata(lrn_rdata),
      .freeze_set(freeze_set), .freeze_clr(freeze_clr), .frozen(frozen),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy));
   // RAM with RD_LAT cycles from address to data
   logic [DW-1:0] ram [1<<AW];
   logic [DW-1:0] dq [RL];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      dq[0] <= ram[mem_addr];
      for (int k = 1; k < RL; k++) dq[k] <= dq[k-1];
   end
   assign mem_dout = dq[RL-1];
   // reference model: memory contents in grant order, expected responses with due cycle
   typedef struct {int due; logic src; logic [DW-1:0] data;} rsp_t;
   rsp_t q[$];
   logic [DW-1:0] mdl [1<<AW];
   int checks = 0, errors = 0, cyc = 0, st = 0, gap = 0;
   bit gap_on = 0;
   logic frz = FR, g_h = 0, g_l = 0, em_we = 0;
   logic [AW-1:0] em_addr = '0;
   logic [DW-1:0] em_din = '0, eh_rd = '0, el_rd = '0;
   int unsigned ph = 0, pl = 0, pfs = 0, pfc = 0;
   task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", n, cyc, act, exp);
      end
   endtask
   // monitor: compares registered outputs and pops read responses as the DUT presents them
   always @(negedge clk) begin : mon
      rsp_t r;
      logic bexp;
      bexp = 0;
      foreach (q[i]) if (q[i].due > cyc) bexp = 1;
      chk("busy", busy, bexp);
      chk("mem_we", mem_we, em_we);
      chk("mem_addr", mem_addr, em_addr);
      chk("mem_din", mem_din, em_din);
      chk("frozen", frozen, frz);
      if (host_rvalid || lrn_rvalid) begin
         if (q.size() == 0) chk("rvalid_spurious", {host_rvalid, lrn_rvalid}, 2'b00);
         else begin
            r = q.pop_front();
            chk("rvalid_cycle", cyc, r.due);
            chk("rvalid_port", {host_rvalid, lrn_rvalid}, r.src ? 2'b01 : 2'b10);
            if (r.src) el_rd = r.data; else eh_rd = r.data;
         end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
         r = q.pop_front();
         chk("rvalid_missing", {host_rvalid, lrn_rvalid}, r.src ? 2'b01 : 2'b10);
      end
      chk("host_rdata", host_rdata, eh_rd);
      chk("lrn_rdata", lrn_rdata, el_rd);
   end
   // advance one clock and apply the previous cycle's grant to the model
   task automatic step();
      logic we, le;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      @(posedge clk);
      cyc++;
      if (rst_n) begin
         le = lrn_req & ~frz;
         em_we = 0;
         if (g_h || g_l) begin
            we = g_h ? host_we : lrn_we;
            a  = g_h ? host_addr : lrn_addr;
            d  = g_h ? host_wdata : lrn_wdata;
            em_we = we; em_addr = a; em_din = d;
            if (we) mdl[a] = d;
            else q.push_back('{cyc + 1 + RL, g_l, mdl[a]});
         end
         if (!le || g_l) st = 0;
         else if (g_h && st < SM) st++;
         if (freeze_set) frz = 1;
         else if (freeze_clr) frz = 0;
      end
      g_h = 0; g_l = 0;
      #1;
   endtask
   task automatic rand_in();
      if (!host_req || g_h) begin
         host_req = $urandom_range(99) < ph; host_we = 1'($urandom_range(1));
         host_addr = AW'($urandom_range(15)); host_wdata = $urandom;
      end
      if (!lrn_req || g_l) begin
         lrn_req = $urandom_range(99) < pl; lrn_we = 1'($urandom_range(1));
         lrn_addr = AW'($urandom_range(15)); lrn_wdata = $urandom;
      end
      freeze_set = $urandom_range(99) < pfs;
      freeze_clr = $urandom_range(99) < pfc;
   endtask
   // expected grant straight from the priority rules
   task automatic gcheck();
      logic le;
      #1;
      le  = lrn_req & ~frz;
      g_l = rst_n & le & (st == SM || !host_req);
      g_h = rst_n & host_req & ~g_l;
      chk("host_gnt", host_gnt, g_h);
      chk("lrn_gnt", lrn_gnt, g_l);
      if (gap_on) begin
         if (lrn_gnt) begin
            chk("starve_gap", gap <= SM + 1, 1'b1);
            gap = 0;
         end else gap++;
      end
   endtask
   task automatic rcyc(int n);
      repeat (n) begin step(); rand_in(); gcheck(); end
   endtask
   task automatic idle_in();
      host_req = 0; lrn_req = 0; freeze_set = 0; freeze_clr = 0;
   endtask
   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         ram[i] = DW'(i * 3);
         mdl[i] = DW'(i * 3);
      end
      repeat (2) step();
      rst_n = 1; gcheck();
      // interleaved host/learner reads of 1..8
      for (int i = 1; i <= 8; i++) begin
         step(); idle_in();
         if (i % 2) begin host_req = 1; host_we = 0; host_addr = AW'(i); end
         else begin lrn_req = 1; lrn_we = 0; lrn_addr = AW'(i); end
         gcheck();
      end
      step(); idle_in(); gcheck();
      repeat (5) begin step(); gcheck(); end
      // host read-after-write
      step(); host_req = 1; host_we = 1; host_addr = 10'h155; host_wdata = 32'hDEADBEEF; gcheck();
      step(); host_we = 0; gcheck();
      step(); idle_in(); gcheck();
      repeat (4) begin step(); gcheck(); end
      // contention with starvation bound
      ph = 100; pl = 100; gap_on = 1; gap = 0;
      rcyc(60);
      gap_on = 0;
      // freeze while learner waits, host keeps going
      step(); rand_in(); freeze_set = 1; gcheck();
      rcyc(20);
      ph = 0;
      step(); rand_in(); freeze_clr = 1; gcheck();
      rcyc(6);
      // simultaneous set and clear: set wins
      step(); rand_in(); freeze_set = 1; freeze_clr = 1; gcheck();
      step(); rand_in(); freeze_clr = 1; gcheck();
      rcyc(3);
      // learner read granted in the freeze_set cycle still returns
      pl = 0;
      rcyc(4);
      step(); idle_in(); lrn_req = 1; lrn_we = 0; lrn_addr = 10'h7; freeze_set = 1; gcheck();
      step(); idle_in(); gcheck();
      repeat (4) begin step(); gcheck(); end
      step(); freeze_clr = 1; gcheck();
      step(); freeze_clr = 0; gcheck();
      // random traffic
      ph = 60; pl = 50; pfs = 3; pfc = 6;
      rcyc(400);
      ph = 0; pl = 0; pfs = 0; pfc = 20;
      rcyc(40);
      // reset one cycle after a host read grant
      step(); idle_in(); host_req = 1; host_we = 0; host_addr = 10'h3; gcheck();
      step(); idle_in();
      rst_n = 0;
      q.delete(); frz = FR; st = 0; em_we = 0; em_addr = '0; em_din = '0; eh_rd = '0; el_rd = '0;
      host_req = 1; gcheck();
      step(); gcheck();
      step(); host_req = 0; rst_n = 1; gcheck();
      repeat (8) begin step(); gcheck(); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
